// File: rtl/counter_x_if.sv
// counter_x_if: GPIO counter port bundle (store strobe, selector, data, count ticks, read-back status)
interface counter_x_if #(parameter int WIDTH = 32);
  logic             counter_we;
  logic [1:0]       counter_ch;
  logic [WIDTH-1:0] counter_val;
  logic             clk0, clk1, clk2;
  logic [WIDTH-1:0] counter_out;
  logic             counter0_out, counter1_out, counter2_out;
  modport master (
    output counter_we, counter_ch, counter_val, clk0, clk1, clk2,
    input  counter_out, counter0_out, counter1_out, counter2_out
  );
  modport slave (
    input  counter_we, counter_ch, counter_val, clk0, clk1, clk2,
    output counter_out, counter0_out, counter1_out, counter2_out
  );
endinterface

// File: rtl/counter_x.sv
// counter_x: three-channel programmable 32-bit down-counter on the GPIO counter port
module counter_x #(parameter int WIDTH = 32) (
  input logic        clk,
  input logic        rst,
  counter_x_if.slave bus
);
  logic [2:0][WIDTH-1:0] w_cnt;
  logic [2:0]            w_out;
  logic [2:0]            w_tick_in;
  assign w_tick_in = {bus.clk2, bus.clk1, bus.clk0};
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [WIDTH-1:0] r_cnt, r_reload, w_dec, w_cnt_n;
    logic [1:0]       r_mode;
    logic             r_en, r_out, w_tick, w_wrap, w_ld, w_cw, w_out_n;
    assign w_ld = bus.counter_we && bus.counter_ch == 2'(i);
    assign w_cw = bus.counter_we && bus.counter_ch == 2'd3 && bus.counter_val[1:0] == 2'(i);
    // reload-based modes treat a zero reload as a stalled channel
    always_comb begin
      w_tick  = w_tick_in[i] && r_en;
      w_dec   = r_cnt - WIDTH'(1);
      w_wrap  = w_tick && |r_reload && r_cnt <= WIDTH'(1);
      w_cnt_n = r_cnt;
      w_out_n = r_out;
      case (r_mode)
        2'd0: begin
          w_cnt_n = (w_tick && |r_cnt) ? w_dec : r_cnt;
          w_out_n = r_out || (w_tick && r_cnt == WIDTH'(1));
        end
        2'd1: begin
          w_cnt_n = w_wrap ? r_reload : (w_tick && |r_reload) ? w_dec : r_cnt;
          w_out_n = |r_reload ? w_wrap : r_out;
        end
        2'd2: begin
          w_cnt_n = w_wrap ? r_reload : (w_tick && |r_reload) ? w_dec : r_cnt;
          w_out_n = r_out ^ w_wrap;
        end
        default: begin
          w_cnt_n = w_tick ? w_dec : r_cnt;
          w_out_n = w_tick ? w_dec[WIDTH-1] : r_out;
        end
      endcase
    end
    // a load overrides any tick on its own channel; control writes leave the count path alone
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt    <= '0;
        r_reload <= '0;
        r_mode   <= '0;
        r_en     <= 1'b0;
        r_out    <= 1'b0;
      end else begin
        if (w_ld) begin
          r_cnt    <= bus.counter_val;
          r_reload <= bus.counter_val;
          r_out    <= r_mode == 2'd0 && ~|bus.counter_val;
        end else begin
          r_cnt <= w_cnt_n;
          r_out <= w_out_n;
        end
        if (w_cw) begin
          r_mode <= bus.counter_val[3:2];
          r_en   <= bus.counter_val[4];
        end
      end
    end
    assign w_cnt[i] = r_cnt;
    assign w_out[i] = r_out;
  end
  assign bus.counter_out  = bus.counter_ch == 2'd0 ? w_cnt[0] :
                            bus.counter_ch == 2'd1 ? w_cnt[1] :
                            bus.counter_ch == 2'd2 ? w_cnt[2] : '0;
  assign bus.counter0_out = w_out[0];
  assign bus.counter1_out = w_out[1];
  assign bus.counter2_out = w_out[2];
endmodule

// File: tb/tb_counter_x.sv
// tb_counter_x: vector table, corner sequences and randomized run against a behavioural model
module tb_counter_x;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  counter_x_if #(.WIDTH(32)) bus();
  counter_x #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    bit        we;
    bit [1:0]  ch;
    bit [31:0] val;
    bit [2:0]  t;
    bit [31:0] exp;
    bit [2:0]  fl;
  } vec_t;
  vec_t tbl[$];
  int n_chk = 0, n_pass = 0;
  bit [31:0] m_cnt[3], m_rel[3];
  bit [1:0]  m_mode[3];
  bit        m_en[3], m_out[3];
  function automatic void add(bit we, bit [1:0] ch, bit [31:0] val, bit [2:0] t, bit [31:0] exp, bit [2:0] fl);
    tbl.push_back('{we, ch, val, t, exp, fl});
  endfunction
  function automatic void m_reset();
    for (int n = 0; n < 3; n++) begin
      m_cnt[n] = 0; m_rel[n] = 0; m_mode[n] = 0; m_en[n] = 0; m_out[n] = 0;
    end
  endfunction
  function automatic void m_step(bit we, bit [1:0] ch, bit [31:0] val, bit [2:0] t);
    for (int n = 0; n < 3; n++) begin
      bit tk;
      tk = t[n] && m_en[n];
      if (we && ch == n[1:0]) begin
        m_cnt[n] = val;
        m_rel[n] = val;
        m_out[n] = (m_mode[n] == 0 && val == 0);
      end else if (m_mode[n] == 0) begin
        if (tk && m_cnt[n] > 0) begin
          m_cnt[n] = m_cnt[n] - 1;
          if (m_cnt[n] == 0) m_out[n] = 1;
        end
      end else if (m_mode[n] == 1) begin
        if (m_rel[n] != 0) begin
          m_out[n] = 0;
          if (tk) begin
            if (m_cnt[n] > 1) m_cnt[n] = m_cnt[n] - 1;
            else begin m_cnt[n] = m_rel[n]; m_out[n] = 1; end
          end
        end
      end else if (m_mode[n] == 2) begin
        if (tk && m_rel[n] != 0) begin
          if (m_cnt[n] > 1) m_cnt[n] = m_cnt[n] - 1;
          else begin m_cnt[n] = m_rel[n]; m_out[n] = !m_out[n]; end
        end
      end else if (tk) begin
        m_cnt[n] = 32'((64'(m_cnt[n]) + 64'hFFFF_FFFF) % 64'h1_0000_0000);
        m_out[n] = m_cnt[n] >= 32'h8000_0000;
      end
    end
    if (we && ch == 3 && val[1:0] != 3) begin
      m_mode[val[1:0]] = val[3:2];
      m_en[val[1:0]]   = val[4];
    end
  endfunction
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic logic [2:0] flags();
    return {bus.counter2_out, bus.counter1_out, bus.counter0_out};
  endfunction
  task automatic drive(bit we, bit [1:0] ch, bit [31:0] val, bit [2:0] t);
    bus.counter_we = we; bus.counter_ch = ch; bus.counter_val = val;
    {bus.clk2, bus.clk1, bus.clk0} = t;
    m_step(we, ch, val, t);
    @(posedge clk); #1;
    bus.counter_we = 1'b0;
    {bus.clk2, bus.clk1, bus.clk0} = 3'b000;
  endtask
  task automatic check_model(string nm);
    for (int c = 0; c < 4; c++) begin
      bus.counter_ch = c[1:0];
      #1;
      check($sformatf("%s cnt ch%0d", nm, c), bus.counter_out, c == 3 ? 32'h0 : m_cnt[c]);
    end
    check($sformatf("%s flags", nm), 32'(flags()), 32'({m_out[2], m_out[1], m_out[0]}));
  endtask
  initial begin
    rst = 1'b1;
    bus.counter_we = 1'b0; bus.counter_ch = 2'd0; bus.counter_val = 32'h0;
    {bus.clk2, bus.clk1, bus.clk0} = 3'b000;
    m_reset();
    add(1, 3, 32'h10, 3'b000, 32'd0, 3'b000);
    add(1, 0, 32'd5,  3'b000, 32'd5, 3'b000);
    for (int k = 4; k >= 1; k--) add(0, 0, 0, 3'b001, 32'(k), 3'b000);
    add(0, 0, 0, 3'b001, 32'd0, 3'b001);
    add(0, 0, 0, 3'b001, 32'd0, 3'b001);
    add(1, 3, 32'h15, 3'b000, 32'd0, 3'b001);
    add(1, 1, 32'd3,  3'b000, 32'd3, 3'b001);
    for (int r = 0; r < 2; r++) begin
      add(0, 1, 0, 3'b010, 32'd2, 3'b001);
      add(0, 1, 0, 3'b010, 32'd1, 3'b001);
      add(0, 1, 0, 3'b010, 32'd3, 3'b011);
    end
    add(0, 1, 0, 3'b000, 32'd3, 3'b001);
    add(1, 3, 32'h1A, 3'b000, 32'd0, 3'b001);
    add(1, 2, 32'd4,  3'b000, 32'd4, 3'b001);
    for (int r = 0; r < 2; r++) begin
      add(0, 2, 0, 3'b100, 32'd3, r == 0 ? 3'b001 : 3'b101);
      add(0, 2, 0, 3'b100, 32'd2, r == 0 ? 3'b001 : 3'b101);
      add(0, 2, 0, 3'b100, 32'd1, r == 0 ? 3'b001 : 3'b101);
      add(0, 2, 0, 3'b100, 32'd4, r == 0 ? 3'b101 : 3'b001);
    end
    add(1, 0, 32'd7, 3'b011, 32'd7, 3'b000);
    add(0, 1, 0,     3'b000, 32'd2, 3'b000);
    add(1, 3, 32'h1C, 3'b000, 32'd0, 3'b000);
    add(1, 0, 32'd0,  3'b000, 32'd0, 3'b000);
    add(0, 0, 0,      3'b001, 32'hFFFF_FFFF, 3'b001);
    add(1, 1, 32'd0,  3'b000, 32'd0, 3'b001);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 3'b010, 32'd0, 3'b001);
    add(1, 1, 32'd6,  3'b000, 32'd6, 3'b001);
    add(0, 1, 0,      3'b010, 32'd5, 3'b001);
    add(1, 3, 32'h05, 3'b000, 32'd0, 3'b001);
    for (int k = 0; k < 10; k++) add(0, 1, 0, 3'b010, 32'd5, 3'b001);
    add(1, 3, 32'h15, 3'b000, 32'd0, 3'b001);
    add(0, 1, 0,      3'b010, 32'd4, 3'b001);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_model("reset");
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].ch, tbl[i].val, tbl[i].t);
      bus.counter_ch = tbl[i].ch;
      #1;
      check($sformatf("vec%0d cnt", i), bus.counter_out, tbl[i].exp);
      check($sformatf("vec%0d flags", i), 32'(flags()), 32'(tbl[i].fl));
    end
    // mode 1 pulse stays one cycle wide even with sparse ticks
    drive(1, 3, 32'h15, 3'b000);
    drive(1, 1, 32'd2, 3'b000);
    drive(0, 1, 0, 3'b010);
    drive(0, 1, 0, 3'b010);
    check("m1 pulse on", 32'(bus.counter1_out), 32'd1);
    drive(0, 1, 0, 3'b000);
    check("m1 pulse off", 32'(bus.counter1_out), 32'd0);
    check_model("m1 sparse");
    // asynchronous reset mid-count, observed before the next clock edge
    drive(0, 1, 0, 3'b111);
    rst = 1'b1;
    m_reset();
    #1;
    check_model("async rst");
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 3'b111);
    check_model("post rst idle");
    for (int it = 0; it < 400; it++) begin
      bit we;
      bit [1:0] ch;
      bit [31:0] val;
      we  = ($urandom_range(0, 3) == 0);
      ch  = 2'($urandom_range(0, 3));
      val = (ch == 3) ? 32'($urandom_range(0, 31)) :
            ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
      drive(we, ch, val, 3'($urandom_range(0, 7)));
      check_model($sformatf("rnd%0d", it));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/counter_x.md
# counter_x

Three-channel 32-bit programmable down-counter that responds to CPU stores on the GPIO counter port and sources counter status back to the bus. The bus decoder asserts `counter_we` and drives `Peripheral_in` for stores to F0000004. The channel or control selector comes from the `counter_set` field latched in the F0000000 GPIO register. Reads return the selected channel's live count on `counter_out`, and the three `counterN_out` flags feed the top bits of the GPIO read word.

## Interface
- `WIDTH`, 32, count/reload width (bus data width).
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `clk0`, `clk1`, `clk2` input 1 each: per-channel count ticks, synchronous to `clk`, one-cycle pulses.
- `counter_we` input 1: write strobe from the bus decoder.
- `counter_ch` input 2: target select from GPIO `counter_set`. 0–2 select a channel; 3 selects the control register.
- `counter_val` input WIDTH: write data, driven from `Peripheral_in`.
- `counter_out` output WIDTH: count of the channel selected by `counter_ch`. Reads 0 when `counter_ch`=3.
- `counter0_out`, `counter1_out`, `counter2_out` output 1 each: per-channel output flags, registered.

## Operation
- Per-channel state:
  - `cnt[WIDTH]`
  - `reload[WIDTH]`
  - `mode[1:0]`
  - `en`
  - `out`
- Load write (`counter_we`=1, `counter_ch`=n<3):
  - `reload[n]` and `cnt[n]` are set to `counter_val`.
  - `out[n]` is set to 0, except mode 0 with `counter_val`=0, which sets `out[n]` to 1.
  - `mode` and `en` are unchanged.
- Control write (`counter_we`=1, `counter_ch`=3):
  - `counter_val[1:0]` selects the channel; value 3 means the write is ignored.
  - `counter_val[3:2]` is written to `mode`, `counter_val[4]` to `en`.
  - `cnt`, `reload` and `out` are unchanged.
- A tick counts only when `en`=1 and the channel's `clkN`=1. Modes:
  - Mode 0, one-shot: if `cnt`>0, decrement. On the 1→0 transition set `out`=1. At 0 the counter holds and `out` stays 1 until the next load.
  - Mode 1, rate: if `cnt`>1, decrement. At `cnt`=1, reload from `reload` and pulse `out`=1 for exactly one `clk` cycle.
  - Mode 2, square: if `cnt`>1, decrement. At `cnt`=1, reload from `reload` and toggle `out`.
  - Mode 3, free-run: decrement with wrap 0→FFFFFFFF; `out` = `cnt[WIDTH-1]` after the update.
- Boundary conditions:
  - Modes 1 and 2 with `reload`=0: the channel stalls, ticks are ignored, `out` holds.
  - Modes 1 and 2 with `reload`=1: a reload fires on every tick.
  - A write to channel n in the same cycle as a tick on n: the write wins and the tick is dropped.
  - A tick on another channel in that cycle is processed normally.
  - Changing `mode` or `en` does not alter `cnt` or `out`. A mode change takes effect on the next tick.
  - Ticks arriving while `en`=0 are lost, not queued.
- `counter_out` is a combinational mux of `cnt[counter_ch]`.

## Timing
- Reset (async, immediate): all `cnt`, `reload`, `mode`, `en` and `out` go to 0. `counter_out` therefore reads 0 and all three flags are 0.
- A write sampled at clk edge k is visible on `counter_out` and the flags after edge k.
- A tick sampled at edge k updates `cnt` and `out` at edge k, so the effect is visible one cycle after the tick is presented.
- Mode 1 `out` pulse width is exactly one `clk` cycle, independent of tick spacing.
- Period in ticks:
  - Mode 1: `reload`.
  - Mode 2: 2×`reload` (the half-period is `reload`).
- Reset asserted mid-count aborts all channels. After release, counting resumes only after new control and load writes.
- No read side effects. Reads never stall; there is no wait state.

## Test plan
- Reset then read: assert `rst` mid-count → all counts read 0 and `counter0_out`..`counter2_out` are 0 immediately, before any clk edge.
- Channel 0 one-shot:
  - Stimulus: control write 0x10 (ch0, mode 0, en), load 5, then 5 `clk0` ticks.
  - Response: `counter_out` reads 5,4,3,2,1,0 across the ticks. `counter0_out` rises after the 5th tick. Further ticks leave the count at 0 and the flag at 1.
- Channel 1 rate:
  - Stimulus: control write 0x15 (ch1, mode 1, en), load 3, then continuous `clk1` ticks.
  - Response: `counter1_out` gives a one-cycle pulse every 3rd tick. The count sequence is 3,2,1,3,2,1.
- Channel 2 square: control write 0x1A (ch2, mode 2, en), load 4, continuous ticks → `counter2_out` toggles every 4 ticks (period 8).
- Collision and edge cases:
  - Load ch0 with 7 in the same cycle as a `clk0` tick → count reads 7, not 6.
  - Mode 3 with load 0 and one tick → count FFFFFFFF and `counter0_out`=1.
  - Mode 1 with reload 0 → the counter stays stalled.
- Disable: clear `en` on ch1 mid-count (write 0x05), apply 10 ticks → count frozen. Re-enable → counting resumes from the frozen value.
